// File: rtl/simple_bus_arbiter_if.sv
// simple_bus_arbiter_if: simple_bus signal bundle; the arbiter is the master, the memory is the slave
interface simple_bus_arbiter_if;
    logic       req;
    logic       gnt;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic [1:0] mode;
    logic       start;
    logic       rdy;
    modport master (output req, addr, wdata, mode, start, input gnt, rdata, rdy);
    modport slave (input req, addr, wdata, mode, start, output gnt, rdata, rdy);
endinterface

// File: rtl/simple_bus_arbiter.sv
// simple_bus_arbiter: round-robin sharing of one simple_bus master port between NUM_REQ requesters.
// Define SIMPLE_BUS_ARB_TIMEOUT_EN to abort REQ/WAIT after TIMEOUT cycles with err_o.
module simple_bus_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_i,
    input  logic [8*NUM_REQ-1:0]   addr_i,
    input  logic [8*NUM_REQ-1:0]   wdata_i,
    input  logic [2*NUM_REQ-1:0]   mode_i,
    output logic [NUM_REQ-1:0]     grant_o,
    output logic [NUM_REQ-1:0]     done_o,
    output logic [7:0]             rdata_o,
    output logic                   err_o,
    simple_bus_arbiter_if.master   bus
);
    localparam int PW = $clog2(NUM_REQ);
    typedef enum logic [1:0] {IDLE, REQ, START, WAIT} state_t;
    state_t r_state, w_state;
    logic [PW-1:0] r_ptr, w_ptr, r_owner, w_owner, w_win, w_k;
    logic [NUM_REQ-1:0] r_grant, w_grant, r_done, w_done;
    logic [7:0] r_rdata, w_rdata, r_addr, w_addr, r_wdata, w_wdata;
    logic [1:0] r_mode, w_mode;
    logic r_req, w_req, r_start, w_start, w_timeout, w_fin;
    logic [7:0] w_addr_a [NUM_REQ];
    logic [7:0] w_wdata_a [NUM_REQ];
    logic [1:0] w_mode_a [NUM_REQ];

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
        assign w_addr_a[k]  = addr_i[8*k +: 8];
        assign w_wdata_a[k] = wdata_i[8*k +: 8];
        assign w_mode_a[k]  = mode_i[2*k +: 2];
    end

    // First requester at or after the pointer wins; the descending scan lets the nearest overwrite.
    always_comb begin
        w_win = '0;
        w_k = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            w_k = PW'((int'(r_ptr) + i) % NUM_REQ);
            if (req_i[w_k]) w_win = w_k;
        end
    end

`ifdef SIMPLE_BUS_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] r_cnt;
    logic r_err;
    always_ff @(posedge clk) begin
        r_cnt <= (rst || (r_state != REQ && r_state != WAIT)) ? '0 : r_cnt + 1'b1;
        r_err <= !rst && w_timeout;
    end
    assign w_timeout = ((r_state == REQ && !bus.gnt) || (r_state == WAIT && !bus.rdy)) && r_cnt == CW'(TIMEOUT - 1);
    assign err_o = r_err;
`else
    assign w_timeout = 1'b0;
    assign err_o = 1'b0;
`endif

    assign w_fin = (r_state == WAIT && bus.rdy) || w_timeout;

    always_comb begin
        w_state = r_state;
        w_ptr = r_ptr;
        w_owner = r_owner;
        w_grant = r_grant;
        w_done = '0;
        w_rdata = r_rdata;
        w_addr = r_addr;
        w_wdata = r_wdata;
        w_mode = r_mode;
        w_req = r_req;
        w_start = 1'b0;
        case (r_state)
            IDLE: if (|req_i) begin
                w_state = REQ;
                w_owner = w_win;
                w_grant = NUM_REQ'(1) << w_win;
                w_req = 1'b1;
                w_addr = w_addr_a[w_win];
                w_wdata = w_wdata_a[w_win];
                w_mode = w_mode_a[w_win];
            end
            REQ: if (bus.gnt) begin
                w_state = START;
                w_start = 1'b1;
            end
            START: w_state = WAIT;
            default: ;
        endcase
        if (w_fin) begin
            w_state = IDLE;
            w_done = NUM_REQ'(1) << r_owner;
            w_grant = '0;
            w_req = 1'b0;
            w_rdata = w_timeout ? 8'h00 : bus.rdata;
            w_ptr = (r_owner == PW'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr <= '0;
            r_owner <= '0;
            r_grant <= '0;
            r_done <= '0;
            r_rdata <= '0;
            r_addr <= '0;
            r_wdata <= '0;
            r_mode <= '0;
            r_req <= 1'b0;
            r_start <= 1'b0;
        end else begin
            r_state <= w_state;
            r_ptr <= w_ptr;
            r_owner <= w_owner;
            r_grant <= w_grant;
            r_done <= w_done;
            r_rdata <= w_rdata;
            r_addr <= w_addr;
            r_wdata <= w_wdata;
            r_mode <= w_mode;
            r_req <= w_req;
            r_start <= w_start;
        end
    end

    assign grant_o = r_grant;
    assign done_o = r_done;
    assign rdata_o = r_rdata;
    assign bus.req = r_req;
    assign bus.addr = r_addr;
    assign bus.wdata = r_wdata;
    assign bus.mode = r_mode;
    assign bus.start = r_start;
endmodule

// File: tb/tb_simple_bus_arbiter.sv
// tb_simple_bus_arbiter: directed scenarios plus randomized traffic checked against a transaction-level model
module tb_simple_bus_arbiter;
    localparam int N = 4;
    localparam int TO = 8;
`ifdef SIMPLE_BUS_ARB_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic [N-1:0] req_i;
    logic [8*N-1:0] addr_i, wdata_i;
    logic [2*N-1:0] mode_i;
    logic [N-1:0] grant_o, done_o;
    logic [7:0] rdata_o;
    logic err_o;
    simple_bus_arbiter_if bus();

    simple_bus_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .mode_i(mode_i), .grant_o(grant_o), .done_o(done_o), .rdata_o(rdata_o),
        .err_o(err_o), .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one owner at a time, phases tracked by the cycle numbers of its events.
    int cyc = 0;
    int m_owner = -1;
    int m_p = 0;
    int t_grant = 0;
    int t_gnt = -1;
    bit m_valid = 0;
    logic [N-1:0] e_grant, e_done;
    logic [7:0] e_rdata, e_addr, e_wdata;
    logic [1:0] e_mode;
    logic e_err, e_req, e_start;

    task automatic model_done(input logic [7:0] d, input logic er);
        e_rdata = d;
        e_err = er;
        e_done = N'(1) << m_owner;
        e_grant = '0;
        e_req = 1'b0;
        m_p = (m_owner + 1) % N;
        m_owner = -1;
    endtask

    initial forever begin
        @(posedge clk);
        e_done = '0;
        e_err = 1'b0;
        e_start = 1'b0;
        if (rst) begin
            m_valid = 1;
            m_owner = -1;
            m_p = 0;
            e_grant = '0;
            e_rdata = '0;
            e_addr = '0;
            e_wdata = '0;
            e_mode = '0;
            e_req = 1'b0;
        end else if (m_owner < 0) begin
            if (req_i != 0) begin
                for (int i = 0; i < N; i++)
                    if (m_owner < 0 && ((req_i >> ((m_p + i) % N)) & 1) != 0) m_owner = (m_p + i) % N;
                e_grant = N'(1) << m_owner;
                e_req = 1'b1;
                e_addr = 8'(addr_i >> (8 * m_owner));
                e_wdata = 8'(wdata_i >> (8 * m_owner));
                e_mode = 2'(mode_i >> (2 * m_owner));
                t_grant = cyc + 1;
                t_gnt = -1;
            end
        end else if (t_gnt < 0) begin
            if (bus.gnt) begin
                t_gnt = cyc;
                e_start = 1'b1;
            end else if (TMO && cyc - t_grant + 1 >= TO) model_done(8'h00, 1'b1);
        end else if (cyc > t_gnt + 1) begin
            if (bus.rdy) model_done(bus.rdata, 1'b0);
            else if (TMO && cyc - (t_gnt + 2) + 1 >= TO) model_done(8'h00, 1'b1);
        end
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (m_valid) begin
            chk("grant_o", grant_o, e_grant);
            chk("done_o", done_o, e_done);
            chk("rdata_o", rdata_o, e_rdata);
            chk("err_o", err_o, e_err);
            chk("bus_req", bus.req, e_req);
            chk("bus_addr", bus.addr, e_addr);
            chk("bus_wdata", bus.wdata, e_wdata);
            chk("bus_mode", bus.mode, e_mode);
            chk("bus_start", bus.start, e_start);
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (grant_o != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("idle_wait", grant_o == 0, 1);
    endtask

    int gq[$];
    int gc[$];
    int rr_exp[5] = '{1, 2, 4, 8, 1};
    logic [N-1:0] prev;

    initial begin
        rst = 1'b1;
        req_i = '0; addr_i = '0; wdata_i = '0; mode_i = '0;
        bus.gnt = 1'b0; bus.rdy = 1'b0; bus.rdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_grant", grant_o, 0);
        chk("reset_req", bus.req, 0);
        // single read
        req_i = 4'b0001; addr_i = 32'h12; wdata_i = 32'hA5; mode_i = 8'b01; bus.gnt = 1'b1;
        @(negedge clk);
        chk("sr_grant", grant_o, 4'b0001);
        chk("sr_addr", bus.addr, 8'h12);
        chk("sr_wdata", bus.wdata, 8'hA5);
        chk("sr_mode", bus.mode, 2'b01);
        chk("sr_start_c1", bus.start, 0);
        req_i = '0;
        @(negedge clk);
        chk("sr_start_c2", bus.start, 1);
        @(negedge clk);
        chk("sr_start_c3", bus.start, 0);
        @(negedge clk);
        chk("sr_done_c4", done_o, 0);
        bus.rdy = 1'b1; bus.rdata = 8'h3C;
        @(negedge clk);
        chk("sr_done_c5", done_o, 4'b0001);
        chk("sr_rdata", rdata_o, 8'h3C);
        chk("sr_req_off", bus.req, 0);
        bus.rdy = 1'b0; bus.rdata = 8'h00;
        @(negedge clk);
        chk("sr_done_c6", done_o, 0);
        chk("sr_rdata_hold", rdata_o, 8'h3C);
        chk("sr_addr_hold", bus.addr, 8'h12);
        // round-robin from reset
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req_i = 4'b1111; bus.gnt = 1'b1; bus.rdy = 1'b1;
        prev = '0;
        for (int i = 0; i < 40 && gq.size() < 5; i++) begin
            @(negedge clk);
            chk("rr_onehot", $countones(grant_o) <= 1, 1);
            if (grant_o != 0 && prev == 0) begin
                gq.push_back(int'(grant_o));
                gc.push_back(i);
            end
            prev = grant_o;
        end
        chk("rr_count", gq.size(), 5);
        for (int k = 0; k < gq.size(); k++) begin
            chk("rr_order", gq[k], rr_exp[k]);
            if (k > 0) chk("rr_gap", gc[k] - gc[k-1], 4);
        end
        req_i = '0;
        wait_idle();
        // wrap: requester 1 completes, then 0 wins over 1
        req_i = 4'b0010;
        @(negedge clk);
        chk("wrap_g1", grant_o, 4'b0010);
        req_i = '0;
        wait_idle();
        req_i = 4'b0011;
        @(negedge clk);
        chk("wrap_g0", grant_o, 4'b0001);
        req_i = '0;
        wait_idle();
        // request drop during WAIT
        req_i = 4'b0100; bus.rdy = 1'b0;
        repeat (3) @(negedge clk);
        req_i = '0;
        @(negedge clk);
        chk("drop_grant", grant_o, 4'b0100);
        bus.rdy = 1'b1;
        @(negedge clk);
        chk("drop_done", done_o, 4'b0100);
        bus.rdy = 1'b0;
        // reset mid-WAIT
        req_i = 4'b0001;
        repeat (3) @(negedge clk);
        rst = 1'b1; req_i = '0;
        @(negedge clk);
        chk("rst_grant", grant_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_req", bus.req, 0);
        chk("rst_addr", bus.addr, 0);
        chk("rst_rdata", rdata_o, 0);
        rst = 1'b0; req_i = 4'b1010;
        @(negedge clk);
        chk("rst_regrant", grant_o, 4'b0010);
        req_i = '0; bus.rdy = 1'b1;
        wait_idle();
        // timeout with bus_gnt stuck low
        bus.gnt = 1'b0; bus.rdy = 1'b0; req_i = 4'b0001;
        @(negedge clk);
        req_i = '0;
        chk("to_grant", grant_o, 4'b0001);
`ifdef SIMPLE_BUS_ARB_TIMEOUT_EN
        repeat (7) @(negedge clk);
        chk("to_req_c8", bus.req, 1);
        chk("to_err_c8", err_o, 0);
        @(negedge clk);
        chk("to_err_c9", err_o, 1);
        chk("to_done_c9", done_o, 4'b0001);
        chk("to_rdata_c9", rdata_o, 8'h00);
        chk("to_req_c9", bus.req, 0);
`else
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("noto_req", bus.req, 1);
            chk("noto_err", err_o, 0);
        end
`endif
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            req_i = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
            addr_i = $urandom; wdata_i = $urandom; mode_i = 8'($urandom);
            bus.gnt = ($urandom_range(0, 2) == 0);
            bus.rdy = ($urandom_range(0, 2) == 0);
            bus.rdata = 8'($urandom);
            @(negedge clk);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
